key_debounce: RTL



---
 rtl/key_debounce.sv | 137 +++++++++++++
 1 files changed

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchronizer plus a four-state debounce FSM that yields a clean level and
// single-cycle press/release pulses. Define KEY_DEBOUNCE_REPEAT_EN to add auto-repeat while held.
module key_debounce #(
  parameter int CNT_N         = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int CW = $clog2(CNT_N);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_N - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            sync1;
  logic            key_s;

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_first;
  logic          rep_hit;

  // The first repeat waits the long delay, later ones use the shorter period.
  assign rep_hit = rep_first ? (rep_cnt == DELAY_LAST) : (rep_cnt == PERIOD_LAST);
`endif

  // Bring the active-low raw key into the clock domain as an active-high level.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync1 <= 1'b0;
      key_s <= 1'b0;
    end else begin
      sync1 <= ~i_key;
      key_s <= sync1;
    end
  end

  // Debounce FSM with shared stability counter and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
      rep_cnt   <= '0;
      rep_first <= 1'b1;
`endif
    end else begin
      o_press   <= 1'b0;
      o_release <= 1'b0;
      case (state)
        IDLE: begin
          if (key_s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!key_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= HELD;
            cnt     <= '0;
            o_level <= 1'b1;
            o_press <= 1'b1;
`ifdef KEY_DEBOUNCE_REPEAT_EN
            rep_cnt   <= '0;
            rep_first <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!key_s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
`ifdef KEY_DEBOUNCE_REPEAT_EN
          else if (rep_hit) begin
            o_press   <= 1'b1;
            rep_cnt   <= '0;
            rep_first <= 1'b0;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
`endif
        end
        RELEASE_WAIT: begin
          // A return to HELD is silent; the repeat schedule restarts from scratch.
          if (key_s) begin
            state <= HELD;
            cnt   <= '0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
            rep_cnt   <= '0;
            rep_first <= 1'b1;
`endif
          end else if (cnt == CNT_LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            o_level   <= 1'b0;
            o_release <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          o_level <= 1'b0;
        end
      endcase
    end
  end

endmodule
